// File: rtl/rf_run_monitor_if.sv
// Bundle between rf_run_monitor and the harness that drives the CPU and reads results.
// With RF_MONITOR_CHECKSUM_EN defined it also carries checksum and clear_chk.
interface rf_run_monitor_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 16
);
  logic                         start;
  logic [NUM_REGS*DATA_W-1:0]   rf_flat;
  logic                         cpu_reset;
  logic                         busy;
  logic                         done;
  logic                         timeout;
  logic [CNT_W-1:0]             cycle_count;
  logic [NUM_REGS-1:0]          nz_mask;
  logic [ADDR_W-1:0]            rd_addr;
  logic [DATA_W-1:0]            rd_data;
`ifdef RF_MONITOR_CHECKSUM_EN
  logic [DATA_W-1:0]            checksum;
  logic                         clear_chk;

  modport master (
    input  start, rf_flat, rd_addr, clear_chk,
    output cpu_reset, busy, done, timeout, cycle_count, nz_mask, rd_data, checksum
  );
  modport slave (
    output start, rf_flat, rd_addr, clear_chk,
    input  cpu_reset, busy, done, timeout, cycle_count, nz_mask, rd_data, checksum
  );
`else
  modport master (
    input  start, rf_flat, rd_addr,
    output cpu_reset, busy, done, timeout, cycle_count, nz_mask, rd_data
  );
  modport slave (
    output start, rf_flat, rd_addr,
    input  cpu_reset, busy, done, timeout, cycle_count, nz_mask, rd_data
  );
`endif
endinterface

// File: rtl/rf_run_monitor.sv
// CPU run harness: sequences CPU reset, detects RF quiescence or timeout, snapshots the RF.
// Optional XOR checksum of the snapshot is enabled by defining RF_MONITOR_CHECKSUM_EN.
module rf_run_monitor #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned QUIET_CYCLES = 16,
  parameter int unsigned MAX_CYCLES   = 4096,
  parameter int unsigned CNT_W        = 16
) (
  input logic           clk,
  input logic           reset,
  rf_run_monitor_if.master bus
);
  localparam int unsigned HoldW  = $clog2(RST_CYCLES + 1);
  localparam int unsigned QuietW = $clog2(QUIET_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StRstHold, StRun, StSnap, StDone} state_e;

  state_e                     state_q;
  logic [HoldW-1:0]           hold_q;
  logic [QuietW-1:0]          quiet_q;
  logic [QuietW-1:0]          quiet_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic [NUM_REGS*DATA_W-1:0] prev_q;
  logic [DATA_W-1:0]          snap_q [NUM_REGS];
  logic [NUM_REGS-1:0]        nz_q;
  logic [NUM_REGS-1:0]        nz_d;
  logic                       cpu_rst_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       tmo_q;
  logic                       quiet_hit;
  logic                       limit_hit;
  logic [DATA_W-1:0]          rd_data_c;
`ifdef RF_MONITOR_CHECKSUM_EN
  logic [DATA_W-1:0]          chk_q;
  logic [DATA_W-1:0]          chk_d;
`endif

  always_comb begin
    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    quiet_d   = (bus.rf_flat == prev_q) ? quiet_q + 1'b1 : '0;
    quiet_hit = (quiet_d == QuietW'(QUIET_CYCLES));
    limit_hit = (32'(cnt_d) >= MAX_CYCLES);
    nz_d      = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      nz_d[i] = |bus.rf_flat[i*DATA_W +: DATA_W];
    end
  end

`ifdef RF_MONITOR_CHECKSUM_EN
  always_comb begin
    chk_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      chk_d = chk_d ^ bus.rf_flat[i*DATA_W +: DATA_W];
    end
  end
`endif

  // Addresses at or beyond NUM_REGS match no entry and read as zero.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr == ADDR_W'(i)) rd_data_c = snap_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      quiet_q   <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      nz_q      <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
`ifdef RF_MONITOR_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
`ifdef RF_MONITOR_CHECKSUM_EN
          if (state_q == StDone && bus.clear_chk) chk_q <= '0;
`endif
          if (bus.start) begin
            state_q   <= StRstHold;
            hold_q    <= HoldW'(RST_CYCLES);
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        StRstHold: begin
          prev_q  <= bus.rf_flat;
          quiet_q <= '0;
          hold_q  <= hold_q - 1'b1;
          if (hold_q == HoldW'(1)) begin
            state_q   <= StRun;
            cpu_rst_q <= 1'b0;
          end
        end
        StRun: begin
          cnt_q   <= cnt_d;
          prev_q  <= bus.rf_flat;
          quiet_q <= quiet_d;
          // Quiescence takes priority when it coincides with the cycle limit.
          if (quiet_hit || limit_hit) begin
            state_q <= StSnap;
            tmo_q   <= !quiet_hit;
          end
        end
        StSnap: begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            snap_q[i] <= bus.rf_flat[i*DATA_W +: DATA_W];
          end
          nz_q      <= nz_d;
`ifdef RF_MONITOR_CHECKSUM_EN
          chk_q     <= chk_d;
`endif
          state_q   <= StDone;
          cpu_rst_q <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cpu_reset   = cpu_rst_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = tmo_q;
  assign bus.cycle_count = cnt_q;
  assign bus.nz_mask     = nz_q;
  assign bus.rd_data     = rd_data_c;
`ifdef RF_MONITOR_CHECKSUM_EN
  assign bus.checksum    = chk_q;
`endif

endmodule

// File: tb/tb_rf_run_monitor.sv
// Bench for rf_run_monitor: run-level reference model on instance A, directed literals on A and B.
module tb_rf_run_monitor;
  localparam int unsigned NR  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned RC  = 2;
  localparam int unsigned QC  = 16;
  localparam int unsigned MC  = 100;
  localparam int unsigned CW  = 16;
  localparam int unsigned NRB = 24;
  localparam int unsigned MCB = 16;
  localparam int          NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_run_monitor_if #(.NUM_REGS(NR),  .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) ifa ();
  rf_run_monitor_if #(.NUM_REGS(NRB), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) ifb ();

  rf_run_monitor #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .RST_CYCLES(RC),
    .QUIET_CYCLES(QC), .MAX_CYCLES(MC), .CNT_W(CW)
  ) u_a (
    .clk(clk), .reset(rst), .bus(ifa)
  );

  rf_run_monitor #(
    .NUM_REGS(NRB), .DATA_W(DW), .ADDR_W(AW), .RST_CYCLES(RC),
    .QUIET_CYCLES(QC), .MAX_CYCLES(MCB), .CNT_W(CW)
  ) u_b (
    .clk(clk), .reset(rst), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model for instance A, phrased as a timeline of edge indices.
  int          n = 0;
  int          t0 = 0;
  int          te = NEVER;
  bit          m_act, m_done, m_tmo;
  int          m_cnt, calm;
  logic [DW-1:0] m_last [NR];
  logic [DW-1:0] m_snap [NR];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_done = 0; m_tmo = 0; m_cnt = 0; calm = 0; te = NEVER;
      for (int i = 0; i < NR; i++) begin
        m_snap[i] = '0;
        m_last[i] = '0;
      end
    end else begin
      bit same;
      n++;
      same = 1;
      for (int i = 0; i < NR; i++) if (ifa.rf_flat[i*DW +: DW] != m_last[i]) same = 0;
      if (m_act && n == te + 1) begin
        for (int i = 0; i < NR; i++) m_snap[i] = ifa.rf_flat[i*DW +: DW];
        m_act  = 0;
        m_done = 1;
      end else if (m_act && te == NEVER && n > t0 + int'(RC)) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        calm = same ? calm + 1 : 0;
        if (calm >= int'(QC)) begin
          te = n; m_tmo = 0;
        end else if (m_cnt >= int'(MC)) begin
          te = n; m_tmo = 1;
        end
      end else if (!m_act && ifa.start) begin
        m_act = 1; t0 = n; te = NEVER; m_done = 0; m_cnt = 0; m_tmo = 0; calm = 0;
      end
      for (int i = 0; i < NR; i++) m_last[i] = ifa.rf_flat[i*DW +: DW];
    end
  end

  always @(negedge clk) begin
    logic [NR-1:0] nz;
    logic          cpu_exp;
    nz = '0;
    for (int i = 0; i < NR; i++) nz[i] = |m_snap[i];
    cpu_exp = !(m_act && n >= t0 + int'(RC) && n <= te);
    chk("m_cpu_reset", 64'(ifa.cpu_reset), 64'(cpu_exp));
    chk("m_busy", 64'(ifa.busy), 64'(m_act));
    chk("m_done", 64'(ifa.done), 64'(m_done));
    chk("m_timeout", 64'(ifa.timeout), 64'(m_tmo));
    chk("m_cycle_count", 64'(ifa.cycle_count), 64'(m_cnt));
    chk("m_nz_mask", 64'(ifa.nz_mask), 64'(nz));
    chk("m_rd_data", 64'(ifa.rd_data), 64'(m_snap[ifa.rd_addr]));
  end

  task automatic start_a();
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
  endtask

  task automatic start_b();
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
  endtask

  task automatic wait_done_a(input int lim, output int cyc);
    cyc = 0;
    while (!ifa.done && cyc < lim) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_done_b(input int lim, output int cyc);
    cyc = 0;
    while (!ifb.done && cyc < lim) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    ifa.start = 1'b0; ifa.rf_flat = '0; ifa.rd_addr = '0;
    ifb.start = 1'b0; ifb.rf_flat = '0; ifb.rd_addr = '0;
`ifdef RF_MONITOR_CHECKSUM_EN
    ifa.clear_chk = 1'b0;
    ifb.clear_chk = 1'b0;
`endif
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_cpu_reset", 64'(ifa.cpu_reset), 64'd1);
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_count", 64'(ifa.cycle_count), 64'd0);
    chk("rst_b_done", 64'(ifb.done), 64'd0);

    // Constant-zero RF: reset held two cycles, finished after 16 quiet RUN cycles.
    start_a();
    chk("t1_cpu_reset_e0", 64'(ifa.cpu_reset), 64'd1);
    @(posedge clk); #1;
    chk("t1_cpu_reset_e1", 64'(ifa.cpu_reset), 64'd1);
    @(posedge clk); #1;
    chk("t1_cpu_reset_e2", 64'(ifa.cpu_reset), 64'd0);
    wait_done_a(200, cyc);
    chk("t1_done", 64'(ifa.done), 64'd1);
    chk("t1_latency", 64'(cyc + 2), 64'd19);
    chk("t1_count", 64'(ifa.cycle_count), 64'd16);
    chk("t1_timeout", 64'(ifa.timeout), 64'd0);
    chk("t1_nz", 64'(ifa.nz_mask), 64'd0);

    // Reg 8 changes for 50 RUN cycles then holds 5.
    ifa.rf_flat = '0;
    start_a();
    ifa.rf_flat[8*DW +: DW] = 32'd100;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 1; k <= 50; k++) begin
      ifa.rf_flat[8*DW +: DW] = (k < 50) ? 32'(100 + k) : 32'd5;
      @(posedge clk); #1;
    end
    wait_done_a(200, cyc);
    chk("t2_done", 64'(ifa.done), 64'd1);
    chk("t2_count", 64'(ifa.cycle_count), 64'd66);
    chk("t2_timeout", 64'(ifa.timeout), 64'd0);
    ifa.rd_addr = 5'd8;
    #1 chk("t2_rd8", 64'(ifa.rd_data), 64'd5);
    chk("t2_nz", 64'(ifa.nz_mask), 64'h100);

    // RF never settles: limit of 100 RUN cycles ends the run.
    ifa.rf_flat = '0;
    ifa.rd_addr = 5'd3;
    start_a();
    for (int i = 0; i < 300 && !ifa.done; i++) begin
      ifa.rf_flat[3*DW +: DW] = i[0] ? 32'd1 : 32'd2;
      @(posedge clk); #1;
    end
    chk("t3_done", 64'(ifa.done), 64'd1);
    chk("t3_timeout", 64'(ifa.timeout), 64'd1);
    chk("t3_count", 64'(ifa.cycle_count), 64'd100);
    chk("t3_nz", 64'(ifa.nz_mask), 64'h8);

    // Reset ten cycles into RUN.
    ifa.rf_flat = '0;
    start_a();
    repeat (RC + 10) @(posedge clk);
    #2;
    chk("t5_running", 64'(ifa.cpu_reset), 64'd0);
    chk("t5_count_pre", 64'(ifa.cycle_count), 64'd10);
    rst = 1'b1;
    #1;
    chk("t5_cpu_reset_async", 64'(ifa.cpu_reset), 64'd1);
    chk("t5_busy", 64'(ifa.busy), 64'd0);
    chk("t5_count", 64'(ifa.cycle_count), 64'd0);
    chk("t5_snap_cleared", 64'(ifa.rd_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_a();
    wait_done_a(200, cyc);
    chk("t5_rerun_done", 64'(ifa.done), 64'd1);
    chk("t5_rerun_count", 64'(ifa.cycle_count), 64'd16);

    // Instance B: limit 16, 24 registers.
    start_b();
    for (int i = 0; i < 200 && !ifb.done; i++) begin
      ifb.rf_flat[0 +: DW] = i[0] ? 32'd7 : 32'd9;
      @(posedge clk); #1;
    end
    chk("b_toggle_done", 64'(ifb.done), 64'd1);
    chk("b_toggle_timeout", 64'(ifb.timeout), 64'd1);
    chk("b_toggle_count", 64'(ifb.cycle_count), 64'd16);

    // Quiescence and limit land on the same cycle: quiescence wins.
    ifb.rf_flat = '0;
    ifb.rf_flat[1*DW +: DW] = 32'hA5;
    ifb.rf_flat[2*DW +: DW] = 32'h0F;
    start_b();
    wait_done_b(200, cyc);
    chk("b_coinc_done", 64'(ifb.done), 64'd1);
    chk("b_coinc_timeout", 64'(ifb.timeout), 64'd0);
    chk("b_coinc_count", 64'(ifb.cycle_count), 64'd16);
    chk("b_nz", 64'(ifb.nz_mask), 64'h6);
    ifb.rd_addr = 5'd1;
    #1 chk("b_rd1", 64'(ifb.rd_data), 64'hA5);
    ifb.rd_addr = 5'd2;
    #1 chk("b_rd2", 64'(ifb.rd_data), 64'h0F);
    ifb.rd_addr = 5'd30;
    #1 chk("b_rd30", 64'(ifb.rd_data), 64'd0);
`ifdef RF_MONITOR_CHECKSUM_EN
    chk("b_checksum", 64'(ifb.checksum), 64'hAA);
    ifb.clear_chk = 1'b1;
    @(posedge clk); #1;
    ifb.clear_chk = 1'b0;
    chk("b_checksum_clr", 64'(ifb.checksum), 64'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
